calculadora_seq: RTL and testbench

Parametrised, handshaked successor to the team's 4-bit combinational calculator. It accepts one operation at a time (add, sub, mul, div) on WIDTH-bit unsigned operands and returns a 2*WIDTH-bit result. Division is computed by a multi-cycle restoring divider that also produces a remainder. Input and output use valid/ready handshakes, and the result is held under backpressure. The block sits between the operand-entry logic and the display/result path.

---
 rtl/calculadora_seq.sv | 146 ++++++++++++++
 tb/tb_calculadora_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/calculadora_seq.sv
// Sequential calculator: add/sub/mul answer one cycle after accept, and division
// uses a restoring divider that produces one quotient bit per cycle.
module calculadora_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 error,
  output logic                 busy
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] part;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             div_zero;
  logic [WIDTH:0]   part_sh;
  logic [WIDTH-1:0] part_sub;
  logic             take;
  logic [WIDTH-1:0] part_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  // Operands are zero-extended to the result width; sub wraps modulo 2^RW.
  function automatic logic [RW-1:0] alu(input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y,
                                        input logic [1:0]       op);
    logic [RW-1:0] xe;
    logic [RW-1:0] ye;
    xe = RW'(x);
    ye = RW'(y);
    case (op)
      2'b00:   return xe + ye;
      2'b01:   return xe - ye;
      default: return xe * ye;
    endcase
  endfunction

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign div_zero = (b == '0);

  // One restoring step; the partial remainder always stays below the divisor,
  // so it fits in WIDTH bits once the trial subtraction is resolved.
  always_comb begin
    part_sh  = {part, dvd[WIDTH-1]};
    part_sub = part_sh[WIDTH-1:0] - dvs;
    take     = (part_sh >= {1'b0, dvs});
    part_nxt = take ? part_sub : part_sh[WIDTH-1:0];
    dvd_nxt  = {dvd[WIDTH-2:0], take};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_sel == 2'b11 && !div_zero) state_nxt = CALC;
          else                              state_nxt = DONE;
        end
      end
      CALC:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      remainder <= '0;
      error     <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      part      <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_sel == 2'b11) begin
              if (div_zero) begin
                result    <= '0;
                remainder <= '0;
                error     <= 1'b1;
                out_valid <= 1'b1;
              end else begin
                dvd  <= a;
                dvs  <= b;
                part <= '0;
                cnt  <= CW'(WIDTH);
              end
            end else begin
              result    <= alu(a, b, op_sel);
              remainder <= '0;
              error     <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        // Divider iteration; the final step publishes quotient and remainder directly.
        CALC: begin
          dvd  <= dvd_nxt;
          part <= part_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result    <= RW'(dvd_nxt);
            remainder <= part_nxt;
            error     <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calculadora_seq.sv
// Bench for calculadora_seq: WIDTH=4 and WIDTH=8 instances driven by directed and
// random operations, checked against a plain-arithmetic reference model.
module tb_calculadora_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv4, ir4, ov4, ordy4, err4, busy4;
  logic [3:0] a4, b4, rm4;
  logic [1:0] op4;
  logic [7:0] res4;

  logic        iv8, ir8, ov8, ordy8, err8, busy8;
  logic [7:0]  a8, b8, rm8;
  logic [1:0]  op8;
  logic [15:0] res8;

  int tests = 0;
  int fails = 0;

  calculadora_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .op_sel(op4), .out_valid(ov4), .out_ready(ordy4), .result(res4),
    .remainder(rm4), .error(err4), .busy(busy4)
  );

  calculadora_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .op_sel(op8), .out_valid(ov8), .out_ready(ordy8), .result(res8),
    .remainder(rm8), .error(err8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] g_rdy(bit w8);  return w8 ? 32'(ir8)   : 32'(ir4);   endfunction
  function automatic logic [31:0] g_ov(bit w8);   return w8 ? 32'(ov8)   : 32'(ov4);   endfunction
  function automatic logic [31:0] g_res(bit w8);  return w8 ? 32'(res8)  : 32'(res4);  endfunction
  function automatic logic [31:0] g_rem(bit w8);  return w8 ? 32'(rm8)   : 32'(rm4);   endfunction
  function automatic logic [31:0] g_err(bit w8);  return w8 ? 32'(err8)  : 32'(err4);  endfunction
  function automatic logic [31:0] g_busy(bit w8); return w8 ? 32'(busy8) : 32'(busy4); endfunction

  // Reference: plain arithmetic on a 2*w-bit result plus the expected latency.
  task automatic model(input int w, input int a, input int b, input int op,
                       output logic [31:0] r, output logic [31:0] m,
                       output logic [31:0] e, output logic [31:0] lat);
    longint md;
    md  = longint'(1) << (2 * w);
    r   = 0;
    m   = 0;
    e   = 0;
    lat = 1;
    case (op)
      0: r = 32'(a + b);
      1: r = 32'((longint'(a) - longint'(b) + md) % md);
      2: r = 32'(a * b);
      default: begin
        if (b == 0) e = 1;
        else begin
          r   = 32'(a / b);
          m   = 32'(a % b);
          lat = 32'(w + 1);
        end
      end
    endcase
  endtask

  task automatic drive(bit w8, logic v, int a, int b, int op);
    if (w8) begin
      iv8 = v; a8 = 8'(a); b8 = 8'(b); op8 = 2'(op);
    end else begin
      iv4 = v; a4 = 4'(a); b4 = 4'(b); op4 = 2'(op);
    end
  endtask

  task automatic set_ordy(bit w8, logic v);
    if (w8) ordy8 = v;
    else    ordy4 = v;
  endtask

  // Issue one op, hold the result for 'hold' cycles with ignored in_valid pulses, then release.
  task automatic run_op(bit w8, int a, int b, int op, int hold, string tag);
    logic [31:0] er, em, ee, elat;
    int cyc;
    model(w8 ? 8 : 4, a, b, op, er, em, ee, elat);
    cyc = 0;
    while (g_rdy(w8) !== 1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/ready"}, g_rdy(w8), 1);
    set_ordy(w8, hold == 0);
    drive(w8, 1'b1, a, b, op);
    @(negedge clk);
    drive(w8, 1'b0, 0, 0, 0);
    cyc = 1;
    while (g_ov(w8) !== 1 && cyc < 100) begin
      check({tag, "/busy_calc"}, g_busy(w8), 1);
      check({tag, "/ready_calc"}, g_rdy(w8), 0);
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, 32'(cyc), elat);
    check({tag, "/result"}, g_res(w8), er);
    check({tag, "/remainder"}, g_rem(w8), em);
    check({tag, "/error"}, g_err(w8), ee);
    check({tag, "/busy_done"}, g_busy(w8), 1);
    check({tag, "/ready_done"}, g_rdy(w8), 0);
    for (int i = 0; i < hold; i++) begin
      drive(w8, 1'b1, int'($urandom), int'($urandom), int'($urandom_range(0, 3)));
      @(negedge clk);
      check({tag, "/hold_valid"}, g_ov(w8), 1);
      check({tag, "/hold_result"}, g_res(w8), er);
      check({tag, "/hold_rem"}, g_rem(w8), em);
      check({tag, "/hold_err"}, g_err(w8), ee);
    end
    drive(w8, 1'b0, 0, 0, 0);
    set_ordy(w8, 1'b1);
    @(negedge clk);
    check({tag, "/valid_fall"}, g_ov(w8), 0);
    check({tag, "/idle_busy"}, g_busy(w8), 0);
    check({tag, "/idle_ready"}, g_rdy(w8), 1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 0, 0);
    ordy4 = 1'b1;
    ordy8 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst/in_ready", 32'(ir4), 0);
    check("rst/out_valid", 32'(ov4), 0);
    check("rst/result", 32'(res4), 0);
    check("rst/remainder", 32'(rm4), 0);
    check("rst/error", 32'(err4), 0);
    check("rst/busy", 32'(busy4), 0);
    check("rst/out_valid8", 32'(ov8), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst/in_ready", 32'(ir4), 1);

    run_op(1'b0, 15, 15, 0, 0, "add15_15");
    run_op(1'b0, 3, 5, 1, 0, "sub3_5");
    run_op(1'b0, 15, 15, 2, 0, "mul15_15");
    run_op(1'b0, 13, 4, 3, 0, "div13_4");
    run_op(1'b0, 9, 0, 3, 0, "div9_0");
    run_op(1'b0, 1, 1, 0, 0, "add1_1");
    run_op(1'b0, 13, 4, 3, 6, "div13_4_bp");
    run_op(1'b0, 0, 0, 1, 0, "sub0_0");

    // Reset two cycles into a division must abort it cleanly.
    drive(1'b0, 1'b1, 13, 4, 3);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    check("abort/busy_before", 32'(busy4), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort/in_ready", 32'(ir4), 0);
    check("abort/out_valid", 32'(ov4), 0);
    check("abort/result", 32'(res4), 0);
    check("abort/remainder", 32'(rm4), 0);
    check("abort/error", 32'(err4), 0);
    check("abort/busy", 32'(busy4), 0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort/no_output", 32'(ov4), 0);
    end
    check("abort/idle_ready", 32'(ir4), 1);

    run_op(1'b1, 255, 1, 3, 0, "div8_255_1");
    run_op(1'b1, 255, 255, 2, 0, "mul8_255_255");
    run_op(1'b1, 0, 255, 1, 0, "sub8_0_255");
    run_op(1'b1, 200, 0, 3, 2, "div8_by0");

    for (int i = 0; i < 30; i++)
      run_op(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand4");
    for (int i = 0; i < 20; i++)
      run_op(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rand8");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
